// File: rtl/taller_ram_arbiter.sv
// Two-master weighted round-robin arbiter for the single-port taller_RAM s1 port.
// Commands are forwarded combinationally; read data returns one cycle after grant.
module taller_ram_arbiter #(
    parameter int unsigned M0_WEIGHT = 1,
    parameter int unsigned M1_WEIGHT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        reset_req,
    input  logic [11:0] m0_address,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [3:0]  m0_byteenable,
    input  logic [31:0] m0_writedata,
    output logic        m0_waitrequest,
    output logic [31:0] m0_readdata,
    output logic        m0_readdatavalid,
    input  logic [11:0] m1_address,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [3:0]  m1_byteenable,
    input  logic [31:0] m1_writedata,
    output logic        m1_waitrequest,
    output logic [31:0] m1_readdata,
    output logic        m1_readdatavalid,
    output logic [11:0] ram_address,
    output logic [3:0]  ram_byteenable,
    output logic [31:0] ram_writedata,
    output logic        ram_chipselect,
    output logic        ram_write,
    input  logic [31:0] ram_readdata,
    output logic        o_dbg_owner,
    output logic [3:0]  o_dbg_cnt
);

    localparam logic [3:0] W0 = M0_WEIGHT[3:0];
    localparam logic [3:0] W1 = M1_WEIGHT[3:0];

    logic       r_owner;
    logic [3:0] r_cnt;
    logic       r_rdpend0;
    logic       r_rdpend1;

    logic       w_req0;
    logic       w_req1;
    logic       w_req_own;
    logic       w_req_oth;
    logic [3:0] w_wown;
    logic       w_gnt_own;
    logic       w_gnt_oth;
    logic       w_gnt0;
    logic       w_gnt1;

    assign w_req0    = m0_read | m0_write;
    assign w_req1    = m1_read | m1_write;
    assign w_req_own = r_owner ? w_req1 : w_req0;
    assign w_req_oth = r_owner ? w_req0 : w_req1;
    assign w_wown    = r_owner ? W1 : W0;

    // Owner keeps the port until its weight is used up, unless the other master is idle.
    assign w_gnt_own = !reset_req & w_req_own & ((r_cnt < w_wown) | !w_req_oth);
    assign w_gnt_oth = !reset_req & !w_gnt_own & w_req_oth;
    assign w_gnt0    = r_owner ? w_gnt_oth : w_gnt_own;
    assign w_gnt1    = r_owner ? w_gnt_own : w_gnt_oth;

    // Avalon handshake: a command is accepted in any cycle where read/write is high
    // and waitrequest is low; waitrequest is only ever high while a request is pending.
    assign m0_waitrequest = w_req0 & !w_gnt0;
    assign m1_waitrequest = w_req1 & !w_gnt1;

    assign ram_address    = w_gnt1 ? m1_address    : m0_address;
    assign ram_byteenable = w_gnt1 ? m1_byteenable : m0_byteenable;
    assign ram_writedata  = w_gnt1 ? m1_writedata  : m0_writedata;
    assign ram_chipselect = w_gnt0 | w_gnt1;
    assign ram_write      = (w_gnt0 & m0_write) | (w_gnt1 & m1_write);

    assign m0_readdata      = ram_readdata;
    assign m1_readdata      = ram_readdata;
    assign m0_readdatavalid = r_rdpend0;
    assign m1_readdatavalid = r_rdpend1;

    assign o_dbg_owner = r_owner;
    assign o_dbg_cnt   = r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_owner   <= 1'b0;
            r_cnt     <= 4'd0;
            r_rdpend0 <= 1'b0;
            r_rdpend1 <= 1'b0;
        end else begin
            if (w_gnt_own) begin
                r_cnt <= (r_cnt < w_wown) ? r_cnt + 4'd1 : w_wown;
            end else if (w_gnt_oth) begin
                r_owner <= !r_owner;
                r_cnt   <= 4'd1;
            end
            // A simultaneous read+write is a write and returns no data.
            r_rdpend0 <= w_gnt0 & m0_read & !m0_write;
            r_rdpend1 <= w_gnt1 & m1_read & !m1_write;
        end
    end

endmodule

// File: tb/tb_taller_ram_arbiter.sv
// Directed bench for taller_ram_arbiter: a 1/1 instance (a) and a 3/1 instance (b)
// share master stimulus, each with its own behavioural RAM.
module tb_taller_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        reset_req;
    logic [11:0] m0_address, m1_address;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic [31:0] m0_writedata, m1_writedata;

    logic        m0_wait_a, m1_wait_a, m0_rdv_a, m1_rdv_a;
    logic [31:0] m0_rd_a, m1_rd_a;
    logic [11:0] ram_addr_a;
    logic [3:0]  ram_be_a;
    logic [31:0] ram_wd_a, ram_rd_a;
    logic        ram_cs_a, ram_wr_a, dbg_owner_a;
    logic [3:0]  dbg_cnt_a;

    logic        m0_wait_b, m1_wait_b, m0_rdv_b, m1_rdv_b;
    logic [31:0] m0_rd_b, m1_rd_b;
    logic [11:0] ram_addr_b;
    logic [3:0]  ram_be_b;
    logic [31:0] ram_wd_b, ram_rd_b;
    logic        ram_cs_b, ram_wr_b, dbg_owner_b;
    logic [3:0]  dbg_cnt_b;

    logic [31:0] mem_a [0:4095];
    logic [31:0] mem_b [0:4095];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    taller_ram_arbiter #(.M0_WEIGHT(1), .M1_WEIGHT(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .reset_req(reset_req),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
        .m0_waitrequest(m0_wait_a), .m0_readdata(m0_rd_a), .m0_readdatavalid(m0_rdv_a),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
        .m1_waitrequest(m1_wait_a), .m1_readdata(m1_rd_a), .m1_readdatavalid(m1_rdv_a),
        .ram_address(ram_addr_a), .ram_byteenable(ram_be_a), .ram_writedata(ram_wd_a),
        .ram_chipselect(ram_cs_a), .ram_write(ram_wr_a), .ram_readdata(ram_rd_a),
        .o_dbg_owner(dbg_owner_a), .o_dbg_cnt(dbg_cnt_a)
    );

    taller_ram_arbiter #(.M0_WEIGHT(3), .M1_WEIGHT(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .reset_req(reset_req),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
        .m0_waitrequest(m0_wait_b), .m0_readdata(m0_rd_b), .m0_readdatavalid(m0_rdv_b),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
        .m1_waitrequest(m1_wait_b), .m1_readdata(m1_rd_b), .m1_readdatavalid(m1_rdv_b),
        .ram_address(ram_addr_b), .ram_byteenable(ram_be_b), .ram_writedata(ram_wd_b),
        .ram_chipselect(ram_cs_b), .ram_write(ram_wr_b), .ram_readdata(ram_rd_b),
        .o_dbg_owner(dbg_owner_b), .o_dbg_cnt(dbg_cnt_b)
    );

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        return r;
    endfunction

    // Behavioural RAMs: registered read, byte-lane writes on the accepting edge.
    always @(posedge clk) begin
        if (ram_cs_a) begin
            if (ram_wr_a) mem_a[ram_addr_a] <= merge(mem_a[ram_addr_a], ram_wd_a, ram_be_a);
            ram_rd_a <= mem_a[ram_addr_a];
        end
        if (ram_cs_b) begin
            if (ram_wr_b) mem_b[ram_addr_b] <= merge(mem_b[ram_addr_b], ram_wd_b, ram_be_b);
            ram_rd_b <= mem_b[ram_addr_b];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_m0(input logic rd, input logic wr, input logic [11:0] a,
                          input logic [3:0] be, input logic [31:0] wd);
        m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = wd;
    endtask

    task automatic set_m1(input logic rd, input logic wr, input logic [11:0] a,
                          input logic [3:0] be, input logic [31:0] wd);
        m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = wd;
    endtask

    task automatic idle_all();
        set_m0(1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
        set_m1(1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
    endtask

    // Advance to the falling edge; inputs are driven there and checked 1 ns later.
    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic do_reset();
        to_neg();
        idle_all();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
    endtask

    logic [7:0] pat_b;
    logic       prev_a;

    initial begin
        pat_b     = 8'b1000_1000;
        reset_n   = 1'b0;
        reset_req = 1'b0;
        idle_all();
        #3;
        check("rst m0_wait", {31'd0, m0_wait_a}, 32'd0);
        check("rst m1_wait", {31'd0, m1_wait_a}, 32'd0);
        check("rst m0_rdv", {31'd0, m0_rdv_a}, 32'd0);
        check("rst m1_rdv", {31'd0, m1_rdv_b}, 32'd0);
        check("rst cs", {31'd0, ram_cs_a}, 32'd0);
        check("rst wr", {31'd0, ram_wr_a}, 32'd0);
        check("rst owner_cnt", {27'd0, dbg_owner_b, dbg_cnt_b}, 32'd0);
        to_neg();
        reset_n = 1'b1;

        // Single write then read on master 0.
        to_neg();
        set_m0(1'b0, 1'b1, 12'h010, 4'hF, 32'hDEADBEEF);
        #1;
        check("wr m0_wait", {31'd0, m0_wait_a}, 32'd0);
        check("wr ram_write", {31'd0, ram_wr_a}, 32'd1);
        to_neg();
        set_m0(1'b1, 1'b0, 12'h010, 4'hF, 32'h0);
        #1;
        check("rd m0_wait", {31'd0, m0_wait_a}, 32'd0);
        check("rd ram_write", {31'd0, ram_wr_a}, 32'd0);
        check("rd rdv early", {31'd0, m0_rdv_a}, 32'd0);
        to_neg();
        idle_all();
        #1;
        check("rd rdv", {31'd0, m0_rdv_a}, 32'd1);
        check("rd data", m0_rd_a, 32'hDEADBEEF);
        check("rd m1_rdv", {31'd0, m1_rdv_a}, 32'd0);
        to_neg();
        #1;
        check("rd rdv one pulse", {31'd0, m0_rdv_a}, 32'd0);

        // Data for master 1 reads.
        to_neg();
        set_m1(1'b0, 1'b1, 12'h020, 4'hF, 32'hC0FFEE01);
        do_reset();

        // Continuous contention from reset: a alternates, b follows 0,0,0,1.
        prev_a = 1'b0;
        for (int k = 0; k < 8; k++) begin
            to_neg();
            set_m0(1'b1, 1'b0, 12'h010, 4'hF, 32'h0);
            set_m1(1'b1, 1'b0, 12'h020, 4'hF, 32'h0);
            #1;
            check($sformatf("eq m0_wait k%0d", k), {31'd0, m0_wait_a}, {31'd0, k[0]});
            check($sformatf("eq m1_wait k%0d", k), {31'd0, m1_wait_a}, {31'd0, !k[0]});
            check($sformatf("wt m0_wait k%0d", k), {31'd0, m0_wait_b}, {31'd0, pat_b[k]});
            check($sformatf("wt m1_wait k%0d", k), {31'd0, m1_wait_b}, {31'd0, !pat_b[k]});
            if (k > 0) begin
                check($sformatf("eq m0_rdv k%0d", k), {31'd0, m0_rdv_a}, {31'd0, !prev_a});
                check($sformatf("eq m1_rdv k%0d", k), {31'd0, m1_rdv_a}, {31'd0, prev_a});
                check($sformatf("eq data k%0d", k), prev_a ? m1_rd_a : m0_rd_a,
                      prev_a ? 32'hC0FFEE01 : 32'hDEADBEEF);
                check($sformatf("wt m1_rdv k%0d", k), {31'd0, m1_rdv_b}, {31'd0, pat_b[k-1]});
            end
            prev_a = k[0];
        end
        for (int k = 8; k < 12; k++) begin
            to_neg();
            set_m1(1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
            #1;
            check($sformatf("solo m0_wait k%0d", k), {31'd0, m0_wait_b}, 32'd0);
        end
        to_neg();
        idle_all();
        #1;
        check("wt cnt sat", {28'd0, dbg_cnt_b}, 32'd3);
        check("wt owner", {31'd0, dbg_owner_b}, 32'd0);

        // Byte lanes across masters.
        to_neg();
        set_m0(1'b0, 1'b1, 12'h0FF, 4'hF, 32'h11223344);
        to_neg();
        idle_all();
        set_m1(1'b0, 1'b1, 12'h0FF, 4'h2, 32'hAABBCCDD);
        #1;
        check("be m1_wait", {31'd0, m1_wait_a}, 32'd0);
        to_neg();
        idle_all();
        set_m0(1'b1, 1'b0, 12'h0FF, 4'hF, 32'h0);
        to_neg();
        idle_all();
        #1;
        check("be rdv", {31'd0, m0_rdv_a}, 32'd1);
        check("be data", m0_rd_a, 32'h1122CC44);

        // reset_req blocks grants but lets an in-flight read complete.
        do_reset();
        to_neg();
        set_m1(1'b1, 1'b0, 12'h020, 4'hF, 32'h0);
        #1;
        check("rr pre m1_wait", {31'd0, m1_wait_a}, 32'd0);
        for (int c = 1; c <= 3; c++) begin
            to_neg();
            reset_req = 1'b1;
            set_m0(1'b1, 1'b0, 12'h010, 4'hF, 32'h0);
            #1;
            check($sformatf("rr m0_wait c%0d", c), {31'd0, m0_wait_a}, 32'd1);
            check($sformatf("rr m1_wait c%0d", c), {31'd0, m1_wait_a}, 32'd1);
            check($sformatf("rr cs c%0d", c), {31'd0, ram_cs_a}, 32'd0);
            check($sformatf("rr m1_rdv c%0d", c), {31'd0, m1_rdv_a}, {31'd0, c == 1});
            if (c == 1) check("rr data", m1_rd_a, 32'hC0FFEE01);
        end
        check("rr owner kept", {31'd0, dbg_owner_a}, 32'd1);
        to_neg();
        reset_req = 1'b0;
        #1;
        check("rr resume m0_wait", {31'd0, m0_wait_a}, 32'd0);
        check("rr resume m1_wait", {31'd0, m1_wait_a}, 32'd1);
        to_neg();
        idle_all();
        #1;
        check("rr resume rdv", {31'd0, m0_rdv_a}, 32'd1);
        check("rr resume data", m0_rd_a, 32'hDEADBEEF);

        // Async reset half a cycle after an m1 read is accepted.
        do_reset();
        to_neg();
        set_m1(1'b1, 1'b0, 12'h020, 4'hF, 32'h0);
        to_neg();
        #1;
        check("ar rdv before", {31'd0, m1_rdv_a}, 32'd1);
        idle_all();
        reset_n = 1'b0;
        #1;
        check("ar rdv dropped", {31'd0, m1_rdv_a}, 32'd0);
        check("ar owner", {31'd0, dbg_owner_a}, 32'd0);
        #1;
        reset_n = 1'b1;
        to_neg();
        set_m0(1'b1, 1'b0, 12'h010, 4'hF, 32'h0);
        set_m1(1'b1, 1'b0, 12'h020, 4'hF, 32'h0);
        #1;
        check("ar m0_wait", {31'd0, m0_wait_a}, 32'd0);
        check("ar m1_wait", {31'd0, m1_wait_a}, 32'd1);
        to_neg();
        idle_all();
        #1;
        check("ar m1_rdv after", {31'd0, m1_rdv_a}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/taller_ram_arbiter.md
# taller_ram_arbiter

Two-master Avalon-MM arbiter that shares the single-port 4096×32 on-chip RAM (`taller_RAM`) between master 0 (Nios II data master) and master 1 (alarm/timekeeping DMA engine). It accepts at most one command per cycle using weighted round-robin. It forwards the winning command combinationally to the RAM port and routes the 1-cycle-latency read data back with a per-master `readdatavalid`. The block sits in the interconnect between both masters and the RAM's `s1` port. The RAM's `clken` input is tied to 1 at the top level.

## Interface
- `M0_WEIGHT`, 1: consecutive grants master 0 may take while master 1 is waiting; legal range 1..15.
- `M1_WEIGHT`, 1: consecutive grants master 1 may take while master 0 is waiting; legal range 1..15.
- `clk`  in  1  single clock for the block and the RAM.
- `reset_n`  in  1  asynchronous, active-low reset.
- `reset_req`  in  1  reset-controller request; while high, no command is granted.
- `m0_address`, `m1_address`  in  12  word address.
- `m0_read`, `m1_read`  in  1  read request.
- `m0_write`, `m1_write`  in  1  write request.
- `m0_byteenable`, `m1_byteenable`  in  4  byte lanes.
- `m0_writedata`, `m1_writedata`  in  32  write data.
- `m0_waitrequest`, `m1_waitrequest`  out  1  high = command not accepted this cycle.
- `m0_readdata`, `m1_readdata`  out  32  both driven directly from `ram_readdata`.
- `m0_readdatavalid`, `m1_readdatavalid`  out  1  read data valid for that master.
- `ram_address`  out  12; `ram_byteenable`  out  4; `ram_writedata`  out  32; `ram_chipselect`  out  1; `ram_write`  out  1.
- `ram_readdata`  in  32  unregistered RAM output, valid the cycle after the address edge.

## Operation
- Request signals: `reqX = mX_read | mX_write`. If read and write are both high, the command is treated as a write and no `readdatavalid` is produced.
- State registers:
  - `owner` (1 bit), reset value 0.
  - `cnt` (4 bits, saturating at the owner's weight), reset value 0.
  - `rdpend0` and `rdpend1`, reset value 0.
- Grant logic (combinational, evaluated each cycle):
  - `reset_req` = 1 → no grant.
  - else if `req[owner]` and (`cnt < W[owner]` or `!req[other]`) → grant `owner`.
  - else if `req[other]` → grant `other`.
  - else → no grant.
- State updates at the clock edge:
  - Grant to `owner` → `cnt <= min(cnt+1, W[owner])`.
  - Grant to `other` → `owner <= other`, `cnt <= 1`.
  - No grant → `owner` and `cnt` unchanged.
- Waitrequest: `mX_waitrequest = reqX & !grantX`. When `reqX` = 0, `mX_waitrequest` is 0.
- RAM drive:
  - `ram_address`, `ram_byteenable` and `ram_writedata` come from the granted master; when there is no grant they come from master 0 (the values are don't-care).
  - `ram_chipselect` = any grant.
  - `ram_write` = grant & `write` of the granted master.
- Read tracking: `rdpendX <= grantX & mX_read & !mX_write` every cycle, and `mX_readdatavalid = rdpendX`.
- Back-to-back reads are supported, including reads that alternate between masters. Each read's data returns exactly one cycle after its grant, in grant order.
- `reset_req` does not clear in-flight `rdpend` flags; the data for an already-granted read is still returned.

## Timing
- Command acceptance happens in the same cycle as the grant: `waitrequest` goes low combinationally, and the RAM captures the command at that clock edge.
- Read latency is 1 cycle: `readdatavalid` is high in the cycle after acceptance, together with `ram_readdata`.
- Write completion is 0 cycles from the master's side; the RAM writes on the acceptance edge.
- Throughput is 1 command per cycle in total.
- Async reset (`reset_n` low) clears `owner`, `cnt` and both `rdpend` flags immediately, so both `readdatavalid` outputs go to 0 without waiting for a clock edge. Any read in flight is dropped.
- Reset outputs (with all requests low): both `waitrequest` = 0, both `readdatavalid` = 0, `ram_chipselect` = 0, `ram_write` = 0.
- First arbitration after reset favours master 0.

## Test plan
- **Single write then read:**
  - Stimulus: m0 writes 0xDEADBEEF to address 0x010 with byteenable 0xF, then reads 0x010.
  - Response: `m0_waitrequest` stays 0 throughout; `m0_readdatavalid` = 1 exactly one cycle after the read is accepted, with data 0xDEADBEEF; `m1_readdatavalid` stays 0.
- **Equal weights (1/1), both masters reading continuously from reset:**
  - Response: grants alternate 0,1,0,1,…; each master sees `waitrequest` high on every other cycle; `readdatavalid` pulses are interleaved, one per cycle.
- **Weighted (M0_WEIGHT=3, M1_WEIGHT=1), both masters requesting continuously:**
  - Response: grant pattern is 0,0,0,1,0,0,0,1.
  - When m1 drops its request, m0 is granted every cycle and `cnt` saturates at 3.
- **Byte lanes across masters:**
  - Stimulus: m0 writes 0x11223344 to 0x0FF with byteenable 0xF; m1 writes 0xAABBCCDD to 0x0FF with byteenable 0x2; m0 reads 0x0FF.
  - Response: read data is 0x1122CC44.
- **reset_req:**
  - Stimulus: `reset_req` held high for 3 cycles while both masters request.
  - Response: both `waitrequest` = 1 and `ram_chipselect` = 0 for those 3 cycles.
  - A read granted in the cycle before `reset_req` rose still gets its `readdatavalid`.
  - Granting resumes with the preserved `owner` once `reset_req` falls.
- **Async reset mid-read:**
  - Stimulus: assert `reset_n` low half a cycle after an m1 read is accepted.
  - Response: `m1_readdatavalid` drops to 0 immediately. After release, the first contended grant goes to m0.
